// File: rtl/conbus_qos_arb.sv
// conbus_qos_arb: seven-master round-robin bus arbiter with a per-grant
// quantum. A master that keeps requesting past its quantum while others
// wait is preempted, unless its transfer is still in flight.
module conbus_qos_arb #(
  parameter int unsigned QUANTUM = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [6:0] req,
  input  logic [6:0] mask,
  input  logic       busy,
  output logic [6:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       preempt
);

  // With QUANTUM=0 preemption is off, so the counter only needs a
  // harmless ceiling; 8'hFF keeps it from wrapping.
  localparam logic [7:0] CNT_SAT    = (QUANTUM == 0) ? 8'hFF : 8'(QUANTUM - 1);
  localparam bit         PREEMPT_EN = (QUANTUM != 0);

  // What the arbiter decides to do on the coming edge.
  typedef enum logic [1:0] {
    DEC_HOLD    = 2'd0,
    DEC_RELEASE = 2'd1,
    DEC_EXPIRE  = 2'd2
  } decision_e;

  logic [2:0] curIdx_q, curIdx_d;
  logic [6:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       preempt_q, preempt_d;

  logic [6:0] ereq;
  logic       curReq;
  logic       othersReq;
  logic       expired;
  logic [2:0] nextIdx;
  logic       found;
  logic [3:0] cand;
  decision_e  decision;

  // Masked requests are the only view of the request lines the arbiter uses.
  always_comb begin
    ereq      = req & ~mask;
    curReq    = ereq[curIdx_q];
    othersReq = |(ereq & ~gnt_q);
    expired   = PREEMPT_EN && curReq && (cnt_q == CNT_SAT) && othersReq && !busy;
  end

  // Round-robin search starting just after the current owner, wrapping mod 7.
  always_comb begin
    nextIdx = curIdx_q;
    found   = 1'b0;
    cand    = 4'd0;
    for (int i = 1; i < 7; i++) begin
      cand = {1'b0, curIdx_q} + 4'(i);
      if (cand >= 4'd7) begin
        cand = cand - 4'd7;
      end
      if (!found && ereq[cand[2:0]]) begin
        nextIdx = cand[2:0];
        found   = 1'b1;
      end
    end
  end

  // A dropped (or masked) request wins over quantum expiry; otherwise hold.
  always_comb begin
    decision = DEC_HOLD;
    if (!curReq && othersReq) begin
      decision = DEC_RELEASE;
    end else if (expired) begin
      decision = DEC_EXPIRE;
    end
  end

  // Next-state: move the grant on a switch decision, else count held cycles.
  always_comb begin
    curIdx_d  = curIdx_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (decision)
      DEC_RELEASE, DEC_EXPIRE: begin
        curIdx_d  = nextIdx;
        gnt_d     = 7'(7'b1 << nextIdx);
        cnt_d     = 8'd0;
        preempt_d = (decision == DEC_EXPIRE);
      end
      default: begin
        if (curReq && (cnt_q != CNT_SAT)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State register; reset parks the grant on master 0 and drops any pending preemption.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      curIdx_q  <= 3'd0;
      gnt_q     <= 7'b0000001;
      cnt_q     <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      curIdx_q  <= curIdx_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = curIdx_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_conbus_qos_arb.sv
// tb_conbus_qos_arb: drives five arbiters (QUANTUM 16, 4, 2, 1, 0) with the
// same directed stimulus, checks every cycle against a behavioural model,
// and pins the model with hand-computed expectations.
module tb_conbus_qos_arb;

  localparam int NINST = 5;
  localparam int QTAB [NINST] = '{16, 4, 2, 1, 0};

  logic       sysClk;
  logic       sysRstN;
  logic [6:0] req;
  logic [6:0] mask;
  logic       busy;

  logic [6:0] gntV  [NINST];
  logic [2:0] idxV  [NINST];
  logic       preV  [NINST];

  int errCount;
  int checkCount;

  // Model state per instance: owning master, cycles held with request, preempt pulse.
  int mOwner [NINST];
  int mHeld  [NINST];
  int mPre   [NINST];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  conbus_qos_arb #(.QUANTUM(16)) dutQ16 (
    .sys_clk(sysClk), .sys_rst_n(sysRstN), .req(req), .mask(mask), .busy(busy),
    .gnt(gntV[0]), .gnt_idx(idxV[0]), .preempt(preV[0]));
  conbus_qos_arb #(.QUANTUM(4)) dutQ4 (
    .sys_clk(sysClk), .sys_rst_n(sysRstN), .req(req), .mask(mask), .busy(busy),
    .gnt(gntV[1]), .gnt_idx(idxV[1]), .preempt(preV[1]));
  conbus_qos_arb #(.QUANTUM(2)) dutQ2 (
    .sys_clk(sysClk), .sys_rst_n(sysRstN), .req(req), .mask(mask), .busy(busy),
    .gnt(gntV[2]), .gnt_idx(idxV[2]), .preempt(preV[2]));
  conbus_qos_arb #(.QUANTUM(1)) dutQ1 (
    .sys_clk(sysClk), .sys_rst_n(sysRstN), .req(req), .mask(mask), .busy(busy),
    .gnt(gntV[3]), .gnt_idx(idxV[3]), .preempt(preV[3]));
  conbus_qos_arb #(.QUANTUM(0)) dutQ0 (
    .sys_clk(sysClk), .sys_rst_n(sysRstN), .req(req), .mask(mask), .busy(busy),
    .gnt(gntV[4]), .gnt_idx(idxV[4]), .preempt(preV[4]));

  // One comparison: counts it and reports a mismatch with both values.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sets the shared inputs; called right after a falling edge.
  task automatic applyStimulus(input logic [6:0] r, input logic [6:0] m, input logic b);
    req  = r;
    mask = m;
    busy = b;
  endtask

  // One arbitration step of the model for instance g, from the rules:
  // who wants the bus, whether the owner still wants it, and how long it has had it.
  task automatic modelStep(input int g);
    logic [6:0] want;
    int         nxt;
    bit         others;
    bit         ownerWants;
    int         cap;
    want   = req & ~mask;
    nxt    = -1;
    others = 1'b0;
    for (int i = 1; i < 7; i++) begin
      int c;
      c = (mOwner[g] + i) % 7;
      if (want[c]) begin
        others = 1'b1;
        if (nxt < 0) nxt = c;
      end
    end
    ownerWants = want[mOwner[g]];
    if (!ownerWants && others) begin
      mOwner[g] = nxt;
      mHeld[g]  = 0;
      mPre[g]   = 0;
    end else if (QTAB[g] > 0 && ownerWants && others && !busy && mHeld[g] >= QTAB[g] - 1) begin
      mOwner[g] = nxt;
      mHeld[g]  = 0;
      mPre[g]   = 1;
    end else begin
      mPre[g] = 0;
      cap = (QTAB[g] == 0) ? 255 : QTAB[g] - 1;
      if (ownerWants && mHeld[g] < cap) mHeld[g]++;
    end
  endtask

  // Model advances on the same edges as the DUTs and resets asynchronously with them.
  always @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      for (int g = 0; g < NINST; g++) begin
        mOwner[g] = 0;
        mHeld[g]  = 0;
        mPre[g]   = 0;
      end
    end else begin
      for (int g = 0; g < NINST; g++) modelStep(g);
    end
  end

  // Every falling edge, each DUT must match the model exactly.
  always @(negedge sysClk) begin
    for (int g = 0; g < NINST; g++) begin
      checkOutput($sformatf("model q%0d gnt", QTAB[g]), gntV[g], 1 << mOwner[g]);
      checkOutput($sformatf("model q%0d gnt_idx", QTAB[g]), idxV[g], mOwner[g]);
      checkOutput($sformatf("model q%0d preempt", QTAB[g]), preV[g], mPre[g]);
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    errCount   = 0;
    checkCount = 0;
    sysRstN    = 1'b0;
    applyStimulus(7'h7F, 7'h00, 1'b0);

    // Held in reset with everyone requesting: master 0 granted, no pulse.
    repeat (3) @(negedge sysClk);
    for (int g = 0; g < NINST; g++) begin
      checkOutput("reset gnt", gntV[g], 'h01);
      checkOutput("reset gnt_idx", idxV[g], 0);
      checkOutput("reset preempt", preV[g], 0);
    end
    sysRstN = 1'b1;

    // All requesting, busy low: Q4 rotates every 4 cycles with a preempt pulse,
    // Q16 keeps master 0 for 16 cycles.
    for (int k = 1; k <= 32; k++) begin
      @(negedge sysClk);
      checkOutput("q4 rotate idx", idxV[1], (k / 4) % 7);
      checkOutput("q4 rotate preempt", preV[1], (k % 4 == 0) ? 1 : 0);
      if (k <= 15) checkOutput("q16 hold gnt", gntV[0], 'h01);
      if (k == 16) begin
        checkOutput("q16 expire gnt", gntV[0], 'h02);
        checkOutput("q16 expire preempt", preV[0], 1);
      end
      if (k == 17) checkOutput("q16 pulse width", preV[0], 0);
    end

    // Reset asserted between edges: master 0 forced at once.
    #2 sysRstN = 1'b0;
    #1;
    for (int g = 0; g < NINST; g++) begin
      checkOutput("async reset gnt", gntV[g], 'h01);
      checkOutput("async reset gnt_idx", idxV[g], 0);
      checkOutput("async reset preempt", preV[g], 0);
    end

    // Busy hold-off: Q2 and Q1 may not switch while busy, then switch with a pulse.
    @(negedge sysClk);
    sysRstN = 1'b1;
    applyStimulus(7'h03, 7'h00, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge sysClk);
      if (k <= 5) begin
        checkOutput("q2 busy hold gnt", gntV[2], 'h01);
        checkOutput("q2 busy hold preempt", preV[2], 0);
      end
      if (k == 5) busy = 1'b0;
      if (k == 6) begin
        checkOutput("q2 after busy gnt", gntV[2], 'h02);
        checkOutput("q2 after busy preempt", preV[2], 1);
      end
      if (k >= 6) begin
        checkOutput("q1 alternate idx", idxV[3], (k % 2 == 0) ? 1 : 0);
        checkOutput("q1 alternate preempt", preV[3], 1);
      end
    end

    // Wrap-around and mask: park on 5, mask it, next is 0 via wrap, then 3.
    applyStimulus(7'h20, 7'h00, 1'b0);
    @(negedge sysClk);
    for (int g = 0; g < NINST; g++) checkOutput("move to 5 gnt", gntV[g], 'h20);
    applyStimulus(7'h29, 7'h20, 1'b0);
    @(negedge sysClk);
    for (int g = 0; g < NINST; g++) begin
      checkOutput("mask wrap gnt", gntV[g], 'h01);
      checkOutput("mask wrap preempt", preV[g], 0);
    end
    applyStimulus(7'h28, 7'h20, 1'b0);
    @(negedge sysClk);
    for (int g = 0; g < NINST; g++) begin
      checkOutput("drop to 3 gnt", gntV[g], 'h08);
      checkOutput("drop to 3 gnt_idx", idxV[g], 3);
    end

    // QUANTUM=0: master 0 holds through 100 contended cycles, leaves on drop.
    applyStimulus(7'h03, 7'h00, 1'b0);
    @(negedge sysClk);
    for (int g = 0; g < NINST; g++) checkOutput("back to 0 gnt", gntV[g], 'h01);
    repeat (100) begin
      @(negedge sysClk);
      checkOutput("q0 no switch gnt", gntV[4], 'h01);
      checkOutput("q0 no preempt", preV[4], 0);
    end
    applyStimulus(7'h02, 7'h00, 1'b0);
    @(negedge sysClk);
    checkOutput("q0 drop gnt", gntV[4], 'h02);
    checkOutput("q0 drop gnt_idx", idxV[4], 1);
    checkOutput("q0 drop preempt", preV[4], 0);

    // Parking on master 4 with no requests, then a lone request from 4.
    applyStimulus(7'h10, 7'h00, 1'b0);
    @(negedge sysClk);
    for (int g = 0; g < NINST; g++) checkOutput("move to 4 gnt", gntV[g], 'h10);
    applyStimulus(7'h00, 7'h00, 1'b0);
    repeat (20) begin
      @(negedge sysClk);
      for (int g = 0; g < NINST; g++) begin
        checkOutput("park gnt", gntV[g], 'h10);
        checkOutput("park gnt_idx", idxV[g], 4);
      end
    end
    applyStimulus(7'h10, 7'h00, 1'b0);
    repeat (10) begin
      @(negedge sysClk);
      for (int g = 0; g < NINST; g++) begin
        checkOutput("lone req gnt", gntV[g], 'h10);
        checkOutput("lone req preempt", preV[g], 0);
      end
    end

    // Mixed patterns of requests, masks and busy, checked only by the model.
    begin
      logic [6:0] reqTab  [8];
      logic [6:0] maskTab [5];
      reqTab  = '{7'h7F, 7'h41, 7'h22, 7'h00, 7'h18, 7'h7F, 7'h05, 7'h60};
      maskTab = '{7'h00, 7'h01, 7'h40, 7'h7F, 7'h08};
      for (int i = 0; i < 96; i++) begin
        applyStimulus(reqTab[(i / 3) % 8], maskTab[(i / 7) % 5], (i % 3 == 1));
        @(negedge sysClk);
      end
    end

    repeat (2) @(negedge sysClk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/conbus_qos_arb.md
CONBUS_QOS_ARB -- requirements
Module: conbus_qos_arb

Interface
REQ-001 SHALL have parameter QUANTUM, default 16, meaning the maximum number of grant cycles held while others wait; legal range 0..255, and 0 disables preemption.
REQ-002 SHALL have port sys_clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 7 bits: per-master bus request (cyc).
REQ-005 SHALL have port mask, input, 7 bits: per-master disable; 1 means the request is ignored.
REQ-006 SHALL have port busy, input, 1 bit: the granted master has a transfer in flight (stb & ~ack).
REQ-007 SHALL have port gnt, output, 7 bits: one-hot grant, registered.
REQ-008 SHALL have port gnt_idx, output, 3 bits: binary index of the set gnt bit, registered (0..6).
REQ-009 SHALL have port preempt, output, 1 bit: one-cycle pulse on the first cycle of a grant that was obtained by quantum expiry.

Function
REQ-010 SHALL form effective request ereq = req & ~mask, combinationally; raw req is not used anywhere else.
REQ-011 SHALL always assert exactly one gnt bit, parking on the last granted master when ereq is all-zero.
REQ-012 SHALL keep an 8-bit cycle counter cnt that clears on every grant change, increments each cycle ereq[cur] is 1, and saturates at QUANTUM-1.
REQ-013 SHALL hold cnt when ereq[cur] is 0.
REQ-014 SHALL pick the next master by round-robin search: cur+1, cur+2, ... cur+6, modulo 7, taking the first set ereq bit.
REQ-015 SHALL release on request drop: if ereq[cur]=0 and some other ereq bit is set, gnt SHALL move to the next master on the following edge, with preempt=0.
REQ-016 SHALL preempt on quantum expiry: if QUANTUM>0, ereq[cur]=1, cnt==QUANTUM-1, another ereq bit is set and busy=0, gnt SHALL move to the next master on the following edge, with preempt=1 for that one cycle.
REQ-017 SHALL NOT switch on quantum expiry while busy=1; it waits with cnt saturated and switches on the first cycle busy=0.
REQ-018 SHALL keep QUANTUM=1 legal: every busy-free cycle with contention switches.
REQ-019 SHALL NOT preempt when QUANTUM=0; the grant is then held until ereq[cur] drops.
REQ-020 SHALL keep the grant when ereq[cur]=1 and no other ereq bit is set, regardless of cnt.
REQ-021 SHALL treat setting mask[cur] identically to a dropped request (REQ-015); busy is ignored in that case.
REQ-022 SHALL have a grant latency of one cycle: gnt and gnt_idx change only on the clock edge after the deciding cycle, never combinationally.
REQ-023 SHALL prioritise simultaneous events: request drop over quantum expiry; the round-robin order alone resolves multiple waiters.
REQ-024 SHALL keep gnt and gnt_idx consistent on every cycle.

Reset
REQ-025 SHALL, while sys_rst_n=0 and asynchronously, set gnt=7'b0000001, gnt_idx=0, cnt=0 and preempt=0.
REQ-026 SHALL, on reset assertion mid-grant, force master 0 immediately and discard any in-flight preemption decision.
REQ-027 SHALL, after sys_rst_n deasserts, evaluate normally from the first rising edge.

Verification
REQ-028 SHALL cover reset: sys_rst_n=0 with req=7'h7F, then release -> gnt=7'h01, gnt_idx=0, preempt=0; master 0 is held while req[0]=1 until cnt reaches 15.
REQ-029 SHALL cover rotation: QUANTUM=4, req=7'h7F constant, busy=0 -> gnt steps 0,1,2,...,6,0, each held exactly 4 cycles, with preempt=1 on the first cycle of each grant.
REQ-030 SHALL cover the busy hold-off: QUANTUM=2, req=7'h03, gnt=master 0, busy=1 for 5 cycles -> gnt stays 7'h01 until the edge after busy falls, then 7'h02 with preempt=1.
REQ-031 SHALL cover wrap-around and mask: gnt=master 5, req=7'h29, mask=7'h20 -> the next grant is master 0 (7'h01) with preempt=0, then master 3 after req[0] drops.
REQ-032 SHALL cover QUANTUM=0: req=7'h03 for 100 cycles with master 0 granted -> no switch and preempt always 0; dropping req[0] -> gnt=7'h02 one cycle later.
REQ-033 SHALL cover parking: req drops to 7'h00 while master 4 is granted -> gnt stays 7'h10 and gnt_idx=4 indefinitely; asserting req=7'h10 causes no change and preempt=0.
